// File: rtl/dma_pkg.sv
// Shared definitions for the DMA master: bus width defaults, length width, FSM states.
package dma_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_RD     = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_WR     = 3'd4,
    ST_DONE   = 3'd5
  } dma_state_e;

  // True in the states that present a bus address (read or write phase).
  function automatic logic is_addr_state(input dma_state_e st);
    return (st == ST_RD) || (st == ST_RDWAIT) || (st == ST_WR);
  endfunction

endpackage

// File: rtl/dma_master_if.sv
// Arbitrated single-master bus between the DMA engine and the memory/arbiter side.
interface dma_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              M_req;
  logic              M_wr;
  logic [ADDR_W-1:0] M_address;
  logic [DATA_W-1:0] M_dout;
  logic              M_grant;
  logic [DATA_W-1:0] M_din;

  modport master (
    output M_req, M_wr, M_address, M_dout,
    input  M_grant, M_din
  );

  modport slave (
    input  M_req, M_wr, M_address, M_dout,
    output M_grant, M_din
  );
endinterface

// File: rtl/dma_master.sv
// Word-copy DMA engine: read src+idx, write dst+idx, three cycles per word under steady grant.
// All outputs are registered from the decode of the next state, so they only move on clk.
module dma_master
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  dma_master_if.master      bus
);

  dma_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_src, r_dst, w_src_nxt, w_dst_nxt;
  logic [LEN_W-1:0]  r_len, r_idx, w_len_nxt, w_idx_nxt, w_idx_inc;
  logic [DATA_W-1:0] r_buf, w_buf_nxt;

  logic              r_busy, r_done, r_req, r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic              w_busy_nxt, w_done_nxt, w_req_nxt, w_wr_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_idx_inc = r_idx + LEN_W'(1);

  // Next-state, operand capture and word-index update.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_src_nxt   = src_addr;
          w_dst_nxt   = dst_addr;
          w_len_nxt   = len;
          w_idx_nxt   = {LEN_W{1'b0}};
          w_state_nxt = (len == {LEN_W{1'b0}}) ? ST_DONE : ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.M_grant) w_state_nxt = ST_RD;
        else             w_state_nxt = ST_REQ;
      end
      ST_RD: begin
        if (bus.M_grant) w_state_nxt = ST_RDWAIT;
        else             w_state_nxt = ST_REQ;
      end
      ST_RDWAIT: begin
        if (bus.M_grant) begin
          w_buf_nxt   = bus.M_din;
          w_state_nxt = ST_WR;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WR: begin
        // A write without grant is not counted; the same word restarts from RD.
        if (bus.M_grant) begin
          w_idx_nxt   = w_idx_inc;
          w_state_nxt = (w_idx_inc == r_len) ? ST_DONE : ST_RD;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_req_nxt  = (w_state_nxt == ST_REQ) || is_addr_state(w_state_nxt);
    w_wr_nxt   = 1'b0;
    w_addr_nxt = {ADDR_W{1'b0}};
    case (w_state_nxt)
      ST_RD, ST_RDWAIT: w_addr_nxt = w_src_nxt + ADDR_W'(w_idx_nxt);
      ST_WR: begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = w_dst_nxt + ADDR_W'(w_idx_nxt);
      end
      default: w_addr_nxt = {ADDR_W{1'b0}};
    endcase
  end

  // State, operand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_src   <= {ADDR_W{1'b0}};
      r_dst   <= {ADDR_W{1'b0}};
      r_len   <= {LEN_W{1'b0}};
      r_idx   <= {LEN_W{1'b0}};
      r_buf   <= {DATA_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_req   <= w_req_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.M_req     = r_req;
  assign bus.M_wr      = r_wr;
  assign bus.M_address = r_addr;
  assign bus.M_dout    = r_buf;

endmodule
